// File: rtl/iterative_alu_if.sv
// Handshake and operand bus between the datapath controller and the iterative ALU.
// The controller drives the request side; the ALU returns status and result.
interface iterative_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  Zero_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  busy_o, done_o, ALU_Result_o, Zero_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output busy_o, done_o, ALU_Result_o, Zero_o
  );
endinterface

// File: rtl/iterative_alu.sv
// Area-reduced execute unit: single-cycle logic/arith ops, shifts done one bit per cycle.
// A start/busy/done handshake lets the controller stall while a shift is in flight.
module iterative_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic            clk,
  input  logic            reset,
  iterative_alu_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_LUI  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  // Shift kind reuses the low two opcode bits: 01 SLL, 10 SRL, 11 SRA.
  localparam logic [1:0] KIND_SLL = 2'b01;
  localparam logic [1:0] KIND_SRL = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [DATA_WIDTH-1:0]  acc_reg, acc_next;
  logic [SHAMT_WIDTH-1:0] cnt_reg, cnt_next;
  logic [1:0]             kind_reg, kind_next;
  logic [DATA_WIDTH-1:0]  result_reg, result_next;
  logic                   zero_reg, zero_next;

  logic [DATA_WIDTH-1:0]  alu_value;
  logic [DATA_WIDTH-1:0]  shl_one;
  logic [DATA_WIDTH-1:0]  shr_one;
  logic [DATA_WIDTH-1:0]  shifted;
  logic                   shr_fill;
  logic                   is_shift;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign shamt    = bus.B_i[SHAMT_WIDTH-1:0];
  assign is_shift = (bus.ALU_Operation_i == OP_SLL) ||
                    (bus.ALU_Operation_i == OP_SRL) ||
                    (bus.ALU_Operation_i == OP_SRA);

  // The MSB of acc never changes under SRA, so it still holds A's sign bit.
  assign shr_fill = (kind_reg == KIND_SRL) ? 1'b0 : acc_reg[DATA_WIDTH-1];

  // One-position shift network, left and right.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_shift_bit
    if (gi == 0) begin : g_lsb
      assign shl_one[gi] = 1'b0;
    end else begin : g_mid_l
      assign shl_one[gi] = acc_reg[gi-1];
    end
    if (gi == DATA_WIDTH - 1) begin : g_msb
      assign shr_one[gi] = shr_fill;
    end else begin : g_mid_r
      assign shr_one[gi] = acc_reg[gi+1];
    end
  end

  assign shifted = (kind_reg == KIND_SLL) ? shl_one : shr_one;

  always_comb begin
    alu_value = '0;
    case (bus.ALU_Operation_i)
      OP_ADD:  alu_value = bus.A_i + bus.B_i;
      OP_SUB:  alu_value = bus.A_i - bus.B_i;
      OP_AND:  alu_value = bus.A_i & bus.B_i;
      OP_OR:   alu_value = bus.A_i | bus.B_i;
      OP_XOR:  alu_value = bus.A_i ^ bus.B_i;
      OP_LUI:  alu_value = bus.B_i;
      OP_SLT:  alu_value = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.A_i) < $signed(bus.B_i))};
      OP_SLTU: alu_value = {{(DATA_WIDTH-1){1'b0}}, (bus.A_i < bus.B_i)};
      default: alu_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      kind_reg   <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      kind_reg   <= kind_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    kind_next   = kind_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          if (is_shift && (shamt != '0)) begin
            acc_next   = bus.A_i;
            cnt_next   = shamt;
            kind_next  = bus.ALU_Operation_i[1:0];
            state_next = SHIFT;
          end else begin
            result_next = is_shift ? bus.A_i : alu_value;
            zero_next   = is_shift ? (bus.A_i == '0) : (alu_value == '0);
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        acc_next = shifted;
        cnt_next = cnt_reg - SHAMT_WIDTH'(1);
        if (cnt_reg == SHAMT_WIDTH'(1)) begin
          result_next = shifted;
          zero_next   = (shifted == '0);
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy_o       = (state_reg != IDLE);
  assign bus.done_o       = (state_reg == DONE);
  assign bus.ALU_Result_o = result_reg;
  assign bus.Zero_o       = zero_reg;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed bench for iterative_alu: expected results queued at start, popped on done_o.
module tb_iterative_alu;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [31:0] exp_q[$];

  iterative_alu_if #(.DATA_WIDTH(32)) bus();

  iterative_alu #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drives one request in the next cycle, then scrambles inputs to prove they were captured.
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input string tag);
    @(negedge clk);
    check({tag, "_idle_busy"}, {31'b0, bus.busy_o}, 32'd0);
    check({tag, "_idle_done"}, {31'b0, bus.done_o}, 32'd0);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = op;
    bus.A_i             = a;
    bus.B_i             = b;
    exp_q.push_back(expv);
    @(negedge clk);
    bus.start_i         = 1'b0;
    bus.ALU_Operation_i = 4'($urandom);
    bus.A_i             = $urandom;
    bus.B_i             = $urandom;
  endtask

  task automatic wait_done(input int cur, input int exp_lat, input string tag);
    int k;
    logic [31:0] expv;
    k = cur;
    while (bus.done_o !== 1'b1 && k < cur + 100) begin
      check({tag, "_busy"}, {31'b0, bus.busy_o}, 32'd1);
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    if (bus.done_o === 1'b1) begin
      check({tag, "_busy_done"}, {31'b0, bus.busy_o}, 32'd1);
      if (exp_q.size() == 0) begin
        check({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        expv = exp_q.pop_front();
        check({tag, "_result"}, bus.ALU_Result_o, expv);
        check({tag, "_zero"}, {31'b0, bus.Zero_o}, {31'b0, (expv == 32'd0)});
      end
    end
    $display("[TB] %s done at cycle %0d result=%h", tag, k, bus.ALU_Result_o);
  endtask

  initial begin
    bit saw_done;
    tests = 0;
    fails = 0;

    // Reset with start raised: reset must win.
    reset               = 1'b1;
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = 4'b0000;
    bus.A_i             = 32'd1;
    bus.B_i             = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_done", {31'b0, bus.done_o}, 32'd0);
      check("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    end
    check("rst_result", bus.ALU_Result_o, 32'd0);
    check("rst_zero", {31'b0, bus.Zero_o}, 32'd1);
    reset       = 1'b0;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("post_rst_done", {31'b0, bus.done_o}, 32'd0);

    start_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add");   wait_done(1, 1, "add");
    start_op(4'b0001, 32'd5, 32'd5, 32'd0, "sub");                   wait_done(1, 1, "sub");
    start_op(4'b1000, 32'hDEAD_0000, 32'h1234_5000, 32'h1234_5000, "lui"); wait_done(1, 1, "lui");
    start_op(4'b0010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, "and"); wait_done(1, 1, "and");
    start_op(4'b0011, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFFF0_FFF0, "or");  wait_done(1, 1, "or");
    start_op(4'b0100, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'hFF00_0FF0, "xor"); wait_done(1, 1, "xor");
    start_op(4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");          wait_done(1, 1, "sltu");
    start_op(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");           wait_done(1, 1, "slt");
    start_op(4'b1111, 32'd5, 32'd7, 32'd0, "op1111");                wait_done(1, 1, "op1111");

    start_op(4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, "sra4");  wait_done(1, 5, "sra4");
    start_op(4'b0110, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, "srl4");  wait_done(1, 5, "srl4");
    start_op(4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "sll31"); wait_done(1, 32, "sll31");
    start_op(4'b0101, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, "sll0");  wait_done(1, 1, "sll0");

    // Busy interlock: an ADD pulsed in cycle 3 of an 8-step SRL must be dropped.
    start_op(4'b0110, 32'hF000_0000, 32'h0000_0008, 32'h00F0_0000, "srl8");
    @(negedge clk);
    @(negedge clk);
    bus.start_i         = 1'b1;
    bus.ALU_Operation_i = 4'b0000;
    bus.A_i             = 32'd1;
    bus.B_i             = 32'd1;
    check("srl8_hold_result", bus.ALU_Result_o, 32'hDEAD_BEEF);
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(4, 9, "srl8");
    start_op(4'b0000, 32'd1, 32'd1, 32'd2, "add_after"); wait_done(1, 1, "add_after");

    // Reset in cycle 6 of a 20-step SLL discards it.
    start_op(4'b0101, 32'd3, 32'd20, 32'h0030_0000, "sll20");
    for (int i = 0; i < 5; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("midrst_busy", {31'b0, bus.busy_o}, 32'd0);
    check("midrst_done", {31'b0, bus.done_o}, 32'd0);
    check("midrst_result", bus.ALU_Result_o, 32'd0);
    check("midrst_zero", {31'b0, bus.Zero_o}, 32'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done_o !== 1'b0) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'b0, saw_done}, 32'd0);
    $display("[TB] midrst reset applied, result=%h zero=%0d", bus.ALU_Result_o, bus.Zero_o);
    start_op(4'b0100, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, "xor2"); wait_done(1, 1, "xor2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
